// File: rtl/k_16_l1dist_fp16_pkg.sv
// -----------------------------------------------------------------------------
// k_dist_pkg
// Shared types and constants for the L1 distance engine: the FSM state
// encoding and the IEEE half-precision field layout used by the converter.
// -----------------------------------------------------------------------------
package k_dist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        CONV = 2'd2
    } dist_state_t;

    localparam int FP16_BIAS   = 15;
    localparam int FP16_MANT_W = 10;
    localparam int FP16_EXP_W  = 5;

endpackage : k_dist_pkg

// File: rtl/k_16_l1dist_fp16_if.sv
// -----------------------------------------------------------------------------
// k_16_l1dist_fp16_if
// Bundles the control, feature and result signals of the L1 distance engine.
//   master : producer of start / feature pairs, consumer of the result
//   slave  : the distance engine itself
// Signals:
//   start, in_valid, a, b   -> engine
//   in_ready, out_valid, out, zero_dist, busy <- engine
// -----------------------------------------------------------------------------
interface k_16_l1dist_fp16_if #(
    parameter int W = 8
);
    logic         start;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic [15:0]  out;
    logic         zero_dist;
    logic         busy;

    modport master (
        output start, in_valid, a, b,
        input  in_ready, out_valid, out, zero_dist, busy
    );

    modport slave (
        input  start, in_valid, a, b,
        output in_ready, out_valid, out, zero_dist, busy
    );
endinterface : k_16_l1dist_fp16_if

// File: rtl/k_16_int2fp16.sv
// -----------------------------------------------------------------------------
// k_16_int2fp16
// Combinational unsigned-integer to FP16 converter.
//   acc       in  ACCW  unsigned integer to convert
//   out       out 16    FP16 value (sign 0); 16'h0000 when acc is zero
//   zero_dist out 1     acc is zero
// The leading one sets the exponent (bias + position); the bits below it are
// left-aligned into the 10-bit mantissa, truncated if there are more than ten.
// -----------------------------------------------------------------------------
module k_16_int2fp16
    import k_dist_pkg::*;
#(
    parameter int ACCW = 10
) (
    input  logic [ACCW-1:0] acc,
    output logic [15:0]     out,
    output logic            zero_dist
);
    localparam int LW = $clog2(ACCW);

    logic [LW-1:0]          lead;
    logic [ACCW-1:0]        norm;
    logic [FP16_EXP_W-1:0]  exp_f;
    logic [FP16_MANT_W-1:0] mant;

    // Highest set bit wins because the loop runs upward.
    always_comb begin
        lead = '0;
        for (int i = 0; i < ACCW; i++) begin
            if (acc[i]) begin
                lead = i[LW-1:0];
            end
        end
    end

    // Shift the leading one up to the MSB; the fraction is everything below it.
    assign norm = acc << (LW'(ACCW - 1) - lead);

    generate
        if (ACCW - 1 >= FP16_MANT_W) begin : g_trunc
            assign mant = norm[ACCW-2 -: FP16_MANT_W];
        end else begin : g_fill
            assign mant = {norm[ACCW-2:0], {(FP16_MANT_W - ACCW + 1){1'b0}}};
        end
    endgenerate

    assign exp_f     = FP16_EXP_W'(FP16_BIAS) + FP16_EXP_W'(lead);
    assign zero_dist = (acc == '0);
    assign out       = zero_dist ? 16'h0000 : {1'b0, exp_f, mant};

endmodule : k_16_int2fp16

// File: rtl/k_16_l1dist_fp16.sv
// -----------------------------------------------------------------------------
// k_16_l1dist_fp16
// Sequential L1 distance engine: accumulates |a-b| over DIM feature pairs,
// then converts the sum to FP16 for the downstream inverse-squarer.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  slave side of k_16_l1dist_fp16_if (start, pair handshake, result)
//
//   state | meaning
//   IDLE  | waiting for start; no pairs accepted
//   ACC   | accepting pairs, acc += |a-b| per accept
//   CONV  | one cycle: acc converted and registered to the outputs
// -----------------------------------------------------------------------------
module k_16_l1dist_fp16
    import k_dist_pkg::*;
#(
    parameter int DIM  = 3,
    parameter int W    = 8,
    parameter int ACCW = W + $clog2(DIM) + 1
) (
    input  logic              clk,
    input  logic              rst,
    k_16_l1dist_fp16_if.slave bus
);
    localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;

    dist_state_t     state, state_nxt;
    logic [ACCW-1:0] acc;
    logic [CW-1:0]   cnt;
    logic            accept;
    logic            last;
    logic [W-1:0]    absdiff;
    logic [15:0]     conv_out;
    logic            conv_zero;
    logic [15:0]     out_q;
    logic            zero_q;
    logic            valid_q;
    logic            in_ready_c;

    assign accept  = bus.in_valid && in_ready_c;
    assign last    = (cnt == CW'(DIM - 1));
    assign absdiff = (bus.a >= bus.b) ? (bus.a - bus.b) : (bus.b - bus.a);

    always_comb begin
        state_nxt  = state;
        in_ready_c = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = ACC;
                end
            end
            ACC: begin
                in_ready_c = 1'b1;
                if (accept && last) begin
                    state_nxt = CONV;
                end
            end
            CONV: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (state == IDLE && bus.start) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc <= acc + ACCW'(absdiff);
            cnt <= cnt + 1'b1;
        end
    end

    k_16_int2fp16 #(
        .ACCW (ACCW)
    ) u_int2fp16 (
        .acc       (acc),
        .out       (conv_out),
        .zero_dist (conv_zero)
    );

    // Result registers hold until the next CONV; valid is a single-cycle strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= (state == CONV);
            if (state == CONV) begin
                out_q  <= conv_out;
                zero_q <= conv_zero;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = valid_q;
    assign bus.out       = out_q;
    assign bus.zero_dist = zero_q;
    assign bus.busy      = (state != IDLE);

endmodule : k_16_l1dist_fp16

// File: tb/tb_k_16_l1dist_fp16.sv
// -----------------------------------------------------------------------------
// tb_k_16_l1dist_fp16
// Directed bench for the L1 distance engine (DIM=3, W=8) with hand-computed
// FP16 results. Inputs change 1 time unit after a rising edge; outputs are
// sampled at that same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_k_16_l1dist_fp16;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    k_16_l1dist_fp16_if #(.W(8)) bus ();

    k_16_l1dist_fp16 #(
        .DIM (3),
        .W   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full gapless distance: start, three pairs, CONV, result cycle, hold cycle.
    task automatic run_dist(input string tag,
                            input logic [7:0] av [3],
                            input logic [7:0] bv [3],
                            input logic [15:0] exp_out,
                            input logic exp_zero);
        bus.in_valid = 1'b0;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        chk({tag, ".in_ready_after_start"}, 16'(bus.in_ready), 16'd1);
        chk({tag, ".busy_after_start"}, 16'(bus.busy), 16'd1);
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = av[i];
            bus.b        = bv[i];
            tick();
        end
        bus.in_valid = 1'b0;
        chk({tag, ".conv_busy"}, 16'(bus.busy), 16'd1);
        chk({tag, ".conv_no_valid"}, 16'(bus.out_valid), 16'd0);
        chk({tag, ".conv_in_ready"}, 16'(bus.in_ready), 16'd0);
        tick();
        chk({tag, ".out_valid"}, 16'(bus.out_valid), 16'd1);
        chk({tag, ".out"}, bus.out, exp_out);
        chk({tag, ".zero_dist"}, 16'(bus.zero_dist), 16'(exp_zero));
        chk({tag, ".busy_idle"}, 16'(bus.busy), 16'd0);
        tick();
        chk({tag, ".valid_drop"}, 16'(bus.out_valid), 16'd0);
        chk({tag, ".out_hold"}, bus.out, exp_out);
        chk({tag, ".zero_hold"}, 16'(bus.zero_dist), 16'(exp_zero));
    endtask

    task automatic pair(input logic [7:0] av, input logic [7:0] bv);
        bus.in_valid = 1'b1;
        bus.a        = av;
        bus.b        = bv;
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        n_assert     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;

        // Reset state
        tick();
        tick();
        chk("rst.out", bus.out, 16'h0000);
        chk("rst.out_valid", 16'(bus.out_valid), 16'd0);
        chk("rst.zero_dist", 16'(bus.zero_dist), 16'd0);
        chk("rst.busy", 16'(bus.busy), 16'd0);
        chk("rst.in_ready", 16'(bus.in_ready), 16'd0);
        rst = 1'b0;
        tick();

        // 6+6+100 = 112 -> 0x5700
        run_dist("d112", '{8'd10, 8'd3, 8'd200}, '{8'd4, 8'd9, 8'd100}, 16'h5700, 1'b0);

        // in_valid while IDLE must not be consumed
        bus.in_valid = 1'b1;
        bus.a        = 8'd50;
        bus.b        = 8'd0;
        tick();
        chk("idle_iv.in_ready", 16'(bus.in_ready), 16'd0);
        tick();
        chk("idle_iv.busy", 16'(bus.busy), 16'd0);
        chk("idle_iv.out_valid", 16'(bus.out_valid), 16'd0);
        bus.in_valid = 1'b0;

        // sum 1 -> 0x3C00
        run_dist("d1", '{8'd5, 8'd0, 8'd0}, '{8'd4, 8'd0, 8'd0}, 16'h3C00, 1'b0);

        // sum 765 -> 0x61FA
        run_dist("d765", '{8'd255, 8'd0, 8'd255}, '{8'd0, 8'd255, 8'd0}, 16'h61FA, 1'b0);

        // all equal -> zero
        run_dist("d0", '{8'd7, 8'd7, 8'd7}, '{8'd7, 8'd7, 8'd7}, 16'h0000, 1'b1);

        // Gaps in in_valid, start during ACC, start in the out_valid cycle
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        pair(8'd10, 8'd4);
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("gap.stall_in_ready", 16'(bus.in_ready), 16'd1);
        tick();
        pair(8'd3, 8'd9);
        tick();
        tick();
        chk("gap.stall_busy", 16'(bus.busy), 16'd1);
        chk("gap.stall_no_valid", 16'(bus.out_valid), 16'd0);
        pair(8'd200, 8'd100);
        chk("gap.conv_no_valid", 16'(bus.out_valid), 16'd0);
        tick();
        chk("gap.out_valid", 16'(bus.out_valid), 16'd1);
        chk("gap.out", bus.out, 16'h5700);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("b2b.in_ready", 16'(bus.in_ready), 16'd1);
        chk("b2b.valid_drop", 16'(bus.out_valid), 16'd0);
        pair(8'd1, 8'd0);
        pair(8'd0, 8'd2);
        pair(8'd3, 8'd0);
        tick();
        chk("b2b.out_valid", 16'(bus.out_valid), 16'd1);
        chk("b2b.out", bus.out, 16'h4600);
        tick();

        // Asynchronous reset after the second accept
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        pair(8'd10, 8'd4);
        pair(8'd3, 8'd9);
        bus.in_valid = 1'b1;
        bus.a        = 8'd200;
        bus.b        = 8'd100;
        #2;
        rst = 1'b1;
        #1;
        chk("arst.out", bus.out, 16'h0000);
        chk("arst.busy", 16'(bus.busy), 16'd0);
        chk("arst.in_ready", 16'(bus.in_ready), 16'd0);
        chk("arst.out_valid", 16'(bus.out_valid), 16'd0);
        chk("arst.zero_dist", 16'(bus.zero_dist), 16'd0);
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("arst.hold_no_valid", 16'(bus.out_valid), 16'd0);
        rst = 1'b0;
        tick();
        chk("arst.after_no_valid", 16'(bus.out_valid), 16'd0);

        // Fresh run after reset
        run_dist("fresh", '{8'd10, 8'd3, 8'd200}, '{8'd4, 8'd9, 8'd100}, 16'h5700, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_k_16_l1dist_fp16
